// File: rtl/buffer_reader.sv
// Burst read controller: drains a fixed number of words from a FIFO
// through a registered valid/ready output stage, then pulses done.
module buffer_reader #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             buf_empty,
  input  logic [WIDTH-1:0] buf_data,
  output logic             buf_pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [LEN_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pop_cnt;
  logic             handshake;

  assign handshake = out_valid && out_ready;

  // Next-state decode and the combinational FIFO read strobe
  always_comb begin
    state_next = state;
    buf_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        buf_pop = !buf_empty && (pop_cnt < len_q) && (!out_valid || out_ready);
        if (handshake && out_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Burst counters and the single-entry output register
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      pop_cnt   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        len_q    <= len;
        pop_cnt  <= '0;
        beat_cnt <= '0;
      end
      if (buf_pop) begin
        out_data  <= buf_data;
        out_valid <= 1'b1;
        out_last  <= (pop_cnt == LEN_W'(len_q - LEN_W'(1)));
        pop_cnt   <= LEN_W'(pop_cnt + LEN_W'(1));
      end else if (handshake) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (handshake) beat_cnt <= LEN_W'(beat_cnt + LEN_W'(1));
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: FIFO model, expected-word scoreboard per burst,
// directed scenarios mixed with random data and random downstream stalls.
module tb_buffer_reader;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             buf_empty;
  logic [WIDTH-1:0] buf_data;
  logic             buf_pop;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic [LEN_W-1:0] beat_cnt;

  buffer_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .buf_empty(buf_empty), .buf_data(buf_data), .buf_pop(buf_pop),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: circular store with read/write indices
  logic [WIDTH-1:0] mem [0:255];
  int wr = 0;
  int rd = 0;
  assign buf_empty = (rd == wr);
  assign buf_data  = mem[rd[7:0]];
  always @(posedge clk) if (buf_pop) rd <= rd + 1;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int dones  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every accepted beat must be the next expected FIFO word
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (buf_pop) chk("pop_while_empty", 64'(buf_empty), 64'd0);
      if (out_valid && !out_ready) chk("pop_during_stall", 64'(buf_pop), 64'd0);
      if (stall_prev) begin
        chk("stall_data_stable", 64'(out_data), 64'(prev_data));
        chk("stall_last_stable", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          chk("beat_data", 64'(out_data), 64'(exp_q[0]));
          chk("beat_last", 64'(out_last), 64'(exp_q.size() == 1));
          void'(exp_q.pop_front());
          beats++;
        end
      end
      if (done) dones++;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr[7:0]] = d;
    wr++;
  endtask

  // Expected words are the next n entries at the FIFO head when start is taken
  task automatic do_start(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(rd + i) & 255]);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggling 1/0, 2: random
  task automatic wait_done(input string tag, input int n, input int mode);
    int d0 = dones;
    int i;
    for (i = 0; i < 300 && !done; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (i % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    out_ready = 1'b1;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(n));
    chk({tag, "_all_beats"}, 64'(exp_q.size()), 64'd0);
    tick();
    chk({tag, "_one_done"}, 64'(dones - d0), 64'd1);
    chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, out_valid, out_last, buf_pop}), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
  endtask

  initial begin
    int b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk_reset_outputs("por");
    reset = 1'b0;

    // Reset during random traffic
    for (int i = 0; i < 20; i++) push($urandom);
    do_start(15);
    for (int i = 0; i < 6; i++) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
    reset = 1'b1;
    tick();
    chk_reset_outputs("rst1");
    tick();
    chk_reset_outputs("rst2");
    reset = 1'b0; out_ready = 1'b1;
    tick();
    do_start(2);
    wait_done("after_rst", 2, 0);

    // Basic burst with exact cycle timing
    while (rd != wr) begin rd = wr; end
    for (int k = 0; k < 4; k++) push(WIDTH'(32'hA0 + k));
    do_start(4);
    chk("basic_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("basic_pop", 64'(buf_pop), 64'd1);
      tick();
      chk("basic_valid", 64'(out_valid), 64'd1);
      chk("basic_data", 64'(out_data), 64'(32'hA0 + k));
      chk("basic_last", 64'(out_last), 64'(k == 3));
    end
    tick();
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_beat_cnt", 64'(beat_cnt), 64'd4);
    tick();
    chk("basic_busy_fall", 64'(busy), 64'd0);

    // Backpressure with alternating ready
    for (int k = 1; k <= 6; k++) push(WIDTH'(k));
    do_start(6);
    wait_done("bp", 6, 1);

    // Starved FIFO: words staged but not visible for 5 cycles
    mem[wr & 255] = 32'h11; mem[(wr + 1) & 255] = 32'h22; mem[(wr + 2) & 255] = 32'h33;
    do_start(3);
    for (int i = 0; i < 5; i++) begin
      chk("starve_no_pop", 64'(buf_pop), 64'd0);
      chk("starve_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    wr = wr + 3;
    wait_done("starve", 3, 0);

    // Zero length burst
    do_start(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_no_pop", 64'({buf_pop, out_valid}), 64'd0);
    tick();
    chk("zero_idle", 64'({busy, done, out_valid}), 64'd0);

    // Start while busy is ignored
    for (int k = 0; k < 7; k++) push($urandom);
    do_start(2);
    start = 1'b1; len = LEN_W'(5);
    tick();
    tick();
    start = 1'b0;
    wait_done("ign", 2, 0);
    repeat (3) tick();
    chk("ign_stays_idle", 64'({busy, buf_pop, out_valid}), 64'd0);

    // Reset after three beats of an 8-beat burst
    while (rd != wr) begin rd = wr; end
    for (int k = 0; k < 12; k++) push($urandom);
    do_start(8);
    b0 = beats;
    for (int i = 0; i < 50 && beats - b0 < 3; i++) tick();
    chk("mid_three_beats", 64'(beats - b0), 64'd3);
    reset = 1'b1;
    tick();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    do_start(2);
    wait_done("mid_restart", 2, 0);

    // Random bursts with random stalls
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) push($urandom);
      do_start(n);
      wait_done("rand", n, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
# buffer_reader

Burst read controller for the draining side of the standard `buffer` FIFO. On a `start` command with a beat count it pops exactly that many words from the FIFO and forwards them through a registered valid/ready output stage, flagging the final beat with `out_last`. It signals completion with a one-cycle `done` pulse. It sits between a request/response FIFO and the downstream consumer (memory port or lane datapath) and sustains 1 beat/cycle.

## Interface
- `WIDTH`, 32, data word width; must match the FIFO `WIDTH`.
- `DEPTH`, 64, depth of the FIFO being drained; sets `LEN_W = $clog2(DEPTH)+1`.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `start`  in  1  burst command; sampled only in IDLE.
- `len`  in  LEN_W  beats in the burst, sampled with `start`; 0 is legal.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `buf_empty`  in  1  FIFO empty flag.
- `buf_data`  in  WIDTH  FIFO head word; combinational, valid whenever `!buf_empty`.
- `buf_pop`  out  1  FIFO read strobe (drives the FIFO `rsp`); combinational.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  WIDTH  output beat data.
- `out_last`  out  1  final beat of the burst; qualified by `out_valid`.
- `out_ready`  in  1  downstream accept.
- `beat_cnt`  out  LEN_W  beats handed off in the current or most recent burst.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: popping and forwarding.
  - DONE: 1 cycle, pulses `done`.
- Transitions:
  - IDLE & `start` & `len`≠0 -> RUN. Latch `len`; clear `pop_cnt`, `beat_cnt`.
  - IDLE & `start` & `len`=0 -> DONE. No pop, no beat.
  - RUN & last beat handshake (`out_valid & out_ready & out_last`) -> DONE.
  - DONE -> IDLE unconditionally.
- `start` outside IDLE is ignored; no queuing.
- Output stage is one register and can load when `!out_valid || out_ready`.
- `buf_pop = RUN & !buf_empty & (pop_cnt < len_q) & (!out_valid || out_ready)`.
- When `buf_pop` is high:
  - `out_data <= buf_data`, `out_valid <= 1`.
  - `out_last <= (pop_cnt == len_q-1)`.
  - `pop_cnt++`.
- On a handshake with no pop in the same cycle, `out_valid <= 0`.
- `beat_cnt` increments on every `out_valid & out_ready`.
- `beat_cnt` holds its value after the burst until the next accepted `start`.
- Counters are `LEN_W` bits and never exceed `len_q`, so they never wrap.
- `len` may exceed the current FIFO occupancy. The block waits on `buf_empty`; there is no timeout.
- `out_data` holds its value when not loaded. It is don't-care while `out_valid` = 0, but never X after reset.
- FIFO contents are not owned here. Reset mid-burst abandons the remaining words in the FIFO.

## Timing
- Reset (synchronous, `reset` = 1 at posedge), value of every output:
  - state = IDLE; `busy`, `done`, `out_valid`, `out_last` = 0.
  - `out_data`, `beat_cnt` = 0; `buf_pop` = 0 (state-gated).
  - Internal `pop_cnt` and `len_q` = 0.
- Reset overrides `start` and any in-flight handshake.
- Latency:
  - `start` at edge N -> RUN from N+1.
  - First `buf_pop` is possible in cycle N+1; the matching `out_valid` appears in cycle N+2.
- Throughput: 1 beat/cycle with `out_ready` = 1 and the FIFO non-empty.
- Backpressure: when `out_valid & !out_ready`, `buf_pop` = 0 and `out_data`/`out_last` are stable.
- Empty: `buf_pop` is never asserted while `buf_empty` = 1.
- A pop and a downstream handshake in the same cycle are legal; the register reloads with no bubble.
- `done` is high the cycle after the last handshake. `busy` falls the cycle after `done`, and a new `start` is accepted there.
- `len`=0: `done` is high in cycle N+1 and there is no pop or beat.

## Test plan
- Reset: assert `reset` 2 cycles mid-random traffic -> next cycle all outputs 0, state IDLE; following `start` (`len`=2) completes normally.
- Basic burst: FIFO holds 0xA0–0xA3, `out_ready`=1, `start` `len`=4 -> `buf_pop` high 4 consecutive cycles from N+1 -> beats 0xA0..0xA3 in cycles N+2..N+5, `out_last` only on 0xA3 -> `done` at N+6, `beat_cnt`=4.
- Backpressure: `len`=6, data 1..6, `out_ready` toggling 1,0,1,0 -> received order 1..6 with no loss or duplication; `buf_pop`=0 in every cycle with `out_valid & !out_ready`; one `done`.
- Starved FIFO: `len`=3, FIFO empty for 5 cycles then 0x11, 0x22, 0x33 written -> no pop while empty, beats 0x11/0x22/0x33, `out_last` on 0x33, `done` follows.
- Zero length and ignored start: `start` `len`=0 -> `done` next cycle, no pop or `out_valid`. `start` (`len`=5) raised while `busy` during a `len`=2 burst -> ignored; exactly 2 beats delivered.
- Reset mid-burst: `len`=8, `reset` after 3 beats -> outputs 0 next cycle; new `start` `len`=2 delivers the next two FIFO words with `out_last` on the second.
